// File: rtl/word_unpacker.sv
// Width-reducing unpacker: one RATIO*WIDTH word in, up to RATIO WIDTH-bit beats out.
// Latency: first beat is valid the cycle after the input handshake; back-to-back words run without a bubble.
// Backpressure: out_ready low freezes the beat; in_ready is high only when idle or when the last beat leaves. Macro: WORD_UNPACKER_MSB_FIRST_EN.
module word_unpacker #(
    parameter int WIDTH = 2**2 * 2**3,
    parameter int RATIO = 2,
    parameter int CNT_W = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RATIO*WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0]       in_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last
);

    // Reject parameter combinations the index counter cannot cover.
    if (RATIO < 2 || RATIO > 16 || (2**CNT_W) < RATIO) begin : g_bad_params
        $error("word_unpacker: illegal RATIO/CNT_W combination");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Highest slice index, and RATIO widened by one bit so RATIO=2**CNT_W still compares correctly.
    localparam logic [CNT_W-1:0] TOP_IDX   = CNT_W'(RATIO - 1);
    localparam logic [CNT_W:0]   RATIO_EXT = (CNT_W+1)'(RATIO);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [RATIO*WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    // Index of the final beat (L-1) rather than L itself, so L=16 fits in CNT_W=4 bits.
    logic [CNT_W-1:0]       last_q, last_d;

    logic                   on_last;
    logic                   in_fire;
    logic                   out_fire;
    logic [CNT_W-1:0]       in_last;
    logic [CNT_W-1:0]       sel;
    logic [WIDTH-1:0]       sel_slice;
    logic [WIDTH-1:0]       slices [RATIO];

    // Split the buffered word into addressable slices.
    for (genvar k = 0; k < RATIO; k++) begin : g_slice
        assign slices[k] = buf_q[k*WIDTH +: WIDTH];
    end

    assign on_last  = (state_q == BUSY) && (idx_q == last_q);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Effective final index of an incoming word: in_len of 0 or beyond RATIO means a full word.
    always_comb begin
        in_last = TOP_IDX;
        if (in_len != '0 && {1'b0, in_len} <= RATIO_EXT) begin
            in_last = in_len - ONE;
        end
    end

    // Map the beat number onto a slice position; MSB-first walks down from the top slice.
    always_comb begin
`ifdef WORD_UNPACKER_MSB_FIRST_EN
        sel = TOP_IDX - idx_q;
`else
        sel = idx_q;
`endif
    end

    // Slice mux, written as a compare loop so the index width need not match the slice count.
    always_comb begin
        sel_slice = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (sel == CNT_W'(k)) begin
                sel_slice = slices[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a word is busy until its last beat leaves, unless a new word arrives on that edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_fire) state_d = BUSY;
            BUSY: if (out_fire && on_last && !in_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and beat outputs; out_data is forced to zero whenever nothing is presented.
    always_comb begin
        in_ready  = (state_q == IDLE) || (on_last && out_ready);
        out_valid = (state_q == BUSY);
        out_last  = on_last;
        out_data  = (state_q == BUSY) ? sel_slice : '0;
    end

    // Datapath next-state: load on input handshake, step on non-final output handshake, clear on drain.
    always_comb begin
        buf_d  = buf_q;
        idx_d  = idx_q;
        last_d = last_q;
        if (in_fire) begin
            buf_d  = in_data;
            idx_d  = '0;
            last_d = in_last;
        end else if (out_fire) begin
            if (on_last) begin
                buf_d  = '0;
                idx_d  = '0;
                last_d = '0;
            end else begin
                idx_d  = idx_q + ONE;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_q  <= '0;
            idx_q  <= '0;
            last_q <= '0;
        end else begin
            buf_q  <= buf_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

endmodule

// File: tb/tb_word_unpacker.sv
// Scoreboard bench for word_unpacker: directed scenarios followed by randomized traffic.
// Each accepted word is expanded into expected beats by arithmetic on the word and its length.
// A negedge monitor checks handshake signals against the queue depth and compares every presented beat.
module tb_word_unpacker;

    localparam int WIDTH = 32;
    localparam int RATIO = 2;
    localparam int CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;

    logic                   clock;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [RATIO*WIDTH-1:0] in_data;
    logic [CNT_W-1:0]       in_len;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t q[$];
    logic  rand_rdy  = 1'b0;
    logic  rdy_fixed = 1'b1;

    word_unpacker #(.WIDTH(WIDTH), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_len   (in_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sole driver of out_ready: random or a fixed level, updated just after each rising edge.
    initial out_ready = 1'b1;
    always @(posedge clock) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Monitor and scoreboard.
    always @(negedge clock) begin : mon
        logic  exp_rdy;
        int    len;
        int    pos;
        beat_t b;
        logic [RATIO*WIDTH-1:0] w;
        if (!reset_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
            q.delete();
        end else begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0 && out_valid) begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_last", 64'(out_last), 64'(q[0].l));
                if (out_ready) void'(q.pop_front());
            end else if (!out_valid) begin
                chk("idle_out_data", 64'(out_data), 64'd0);
                chk("idle_out_last", 64'(out_last), 64'd0);
            end
            if (in_valid && exp_rdy) begin
                len = (in_len == 0 || int'(in_len) > RATIO) ? RATIO : int'(in_len);
                for (int j = 0; j < len; j++) begin
`ifdef WORD_UNPACKER_MSB_FIRST_EN
                    pos = RATIO - 1 - j;
`else
                    pos = j;
`endif
                    w   = in_data >> (WIDTH * pos);
                    b.d = w[WIDTH-1:0];
                    b.l = (j == len - 1);
                    q.push_back(b);
                end
            end
        end
    end

    // Present a word until accepted; returns just after the accepting edge.
    task automatic send(input logic [RATIO*WIDTH-1:0] d, input logic [CNT_W-1:0] l);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        n = 0;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic set_rdy(input logic v);
        rdy_fixed = v;
        @(posedge clock);
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clock);
            n++;
        end
        #2;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        in_len   = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clock);
        #2;

        // Basic unpack and short length.
        send(64'h0000_0000_DEAD_BEEF, 4'd0);
        drain();
        send(64'hAAAA_AAAA_5555_5555, 4'd1);
        drain();

        // Back-to-back words with in_valid held high.
        send(64'h1111_1111_2222_2222, 4'd0);
        send(64'h3333_3333_4444_4444, 4'd0);
        drain();

        // Backpressure on beat 0 for several cycles, then release.
        set_rdy(1'b0);
        send(64'h0000_0000_DEAD_BEEF, 4'd0);
        repeat (5) @(posedge clock);
        #2;
        chk("bp_beat0_held", 64'(out_data), 64'(32'hDEADBEEF));
        set_rdy(1'b1);
        drain();

        // Reset in the middle of a word.
        send(64'h0000_0000_DEAD_BEEF, 4'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        send(64'h0000_0001_0000_0002, 4'd0);
        drain();

        // Randomized traffic with random lengths (including out-of-range) and random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #2;
            end
            send({$urandom, $urandom}, CNT_W'($urandom_range(0, 15)));
        end
        rand_rdy = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Width-reducing unpacker; the inverse of the team's zero-extend/pack path that places a 32-bit value into a 64-bit word.
- Accepts one wide word of RATIO*WIDTH bits over a valid/ready handshake.
- Emits its slices one WIDTH-bit beat per accepted output handshake, least-significant slice first by default.
- Sits between a wide datapath register stage and a narrow consumer.

Parameters:
- WIDTH, default 2**2 * 2**3 (=32): output slice width in bits.
- RATIO, default 2: slices per input word; legal range 2..16.
- CNT_W, default 4: width of in_len and the internal slice index; must satisfy 2**CNT_W >= RATIO.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  unpacker can accept a word this cycle.
- in_data  input  RATIO*WIDTH  wide word; slice k is in_data[k*WIDTH +: WIDTH].
- in_len  input  CNT_W  number of slices to emit: 1..RATIO; 0 or >RATIO means RATIO.
- out_valid  output  1  out_data holds a valid slice.
- out_ready  input  1  consumer accepts the slice.
- out_data  output  WIDTH  current slice.
- out_last  output  1  current slice is the final slice of its word.

Behaviour:
- One clock domain. Reset is asynchronous, active-low on reset_n; all state is cleared immediately on assertion.
- Reset values:
  - out_valid=0, out_last=0, out_data=0.
  - in_ready=1 once reset is released.
  - Internal buffer=0, index=0, length=0.
- State machine: IDLE (buffer empty) and BUSY (buffer holds a word).
- IDLE:
  - in_ready=1 and out_valid=0.
  - An input handshake (in_valid & in_ready) at edge N captures in_data and the effective length L, sets index=0 and moves to BUSY.
  - out_valid=1 with slice 0 from edge N; latency is 1 cycle.
- BUSY:
  - out_valid=1.
  - out_data = slice[index], selected combinationally from the registered buffer and index.
  - out_last = (index == L-1).
- Output handshake (out_valid & out_ready) with index < L-1: index increments, other state holds.
- Output handshake with index == L-1:
  - If in_valid is also high, the new word is captured in the same edge. index=0, state stays BUSY; no bubble.
  - Otherwise the state returns to IDLE and out_data returns to 0.
- in_ready = IDLE, or (BUSY & out_ready & index==L-1). This is combinational from out_ready; no combinational path from in_valid to out_*.
- out_valid low, or out_ready low: state, index and out_data hold stable. out_data must not change while out_valid=1 and out_ready=0.
- in_valid while BUSY and not on the last slice: in_ready=0 and the word is not accepted; the source must hold it.
- L=1: exactly one beat is emitted, with out_last=1.
- Index never exceeds L-1 and never wraps past RATIO-1.
- Reset mid-word: remaining slices are discarded; the block restarts in IDLE.
- in_len is sampled only on the input handshake.

Optional Feature:
- Macro: WORD_UNPACKER_MSB_FIRST_EN.
- Defined: slices are emitted most-significant first. Beat j carries slice (RATIO-1-j). With L<RATIO the top L slices are emitted, in descending order.
- Undefined: LSB-first, slices 0..L-1 ascending.
- Handshake, timing, out_last and reset behaviour are identical in both builds.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, out_last=0; after release in_ready=1.
- Basic unpack (WIDTH=32, RATIO=2, in_len=0), in_data=64'h0000_0000_DEAD_BEEF, out_ready=1:
  - Default build: beat0=32'hDEADBEEF, last=0; beat1=32'h00000000, last=1; then IDLE.
  - With MSB_FIRST: beats reversed.
- Back-to-back: words 64'h1111_1111_2222_2222 then 64'h3333_3333_4444_4444 with in_valid held high and out_ready=1 -> beats 22222222, 11111111, 44444444, 33333333 on four consecutive cycles, no bubble.
- Backpressure:
  - out_ready=0 for 5 cycles during beat0 -> out_data stays 32'hDEADBEEF, in_ready=0, index unchanged.
  - Release -> beat1 follows.
- Short length: in_len=1 on 64'hAAAA_AAAA_5555_5555 -> single beat 32'h55555555 with out_last=1 (32'hAAAAAAAA with MSB_FIRST).
- Reset mid-word: assert reset_n=0 after beat0 -> out_valid falls asynchronously. After release, a new word 64'h0000_0001_0000_0002 yields 00000002, then 00000001.
